// File: rtl/fc_inneuron_loader_if.sv
// Input-neuron stream and RAM write bus of the FC input-neuron loader.
// The master side is the neuron producer; the slave side is the loader.
interface fc_inneuron_loader_if #(
    parameter int PI = 2,
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] wr_data_a;
    logic [DW-1:0] wr_data_b;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
    logic [PI-1:0] wren_a;
    logic [PI-1:0] wren_b;

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  wr_data_a, wr_data_b,
        input  wr_addr_a, wr_addr_b,
        input  wren_a, wren_b
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output wr_data_a, wr_data_b,
        output wr_addr_a, wr_addr_b,
        output wren_a, wren_b
    );
endinterface

// File: rtl/fc_inneuron_loader.sv
// Pairs the flattened neuron stream and writes it into the PI input-neuron RAM banks.
// Optional producer-side ReLU clamp when FC_LOADER_RELU_EN is defined.
module fc_inneuron_loader #(
    parameter int INNEURON               = 8,
    parameter int PI                     = 2,
    parameter int DATA_WIDTH_FC          = 16,
    parameter int FC_INNEURON_ADDR_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    fc_inneuron_loader_if.slave bus,
    output logic busy,
    output logic done
);
    localparam int D  = INNEURON / (2 * PI);
    localparam int JW = (D > 1) ? $clog2(D) : 1;
    localparam int BW = (PI > 1) ? $clog2(PI) : 1;
    localparam int DW = DATA_WIDTH_FC;
    localparam int AW = FC_INNEURON_ADDR_WIDTH;

    localparam logic [JW-1:0] J_LAST = JW'(D - 1);
    localparam logic [BW-1:0] B_LAST = BW'(PI - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic          phase;
    logic [JW-1:0] j;
    logic [BW-1:0] bank;
    logic [DW-1:0] hold;
    logic [DW-1:0] din;
    logic [PI-1:0] bank_sel;
    logic [AW-1:0] addr_even;
    logic [AW-1:0] addr_odd;
    logic          xfer;
    logic          wr_fire;
    logic          last_pair;
    logic          restart;

`ifdef FC_LOADER_RELU_EN
    assign din = bus.in_data[DW-1] ? '0 : bus.in_data;
`else
    assign din = bus.in_data;
`endif

    assign bus.in_ready = (state == S_FILL);
    assign busy         = (state == S_FILL);
    assign done         = (state == S_DONE);

    assign xfer      = bus.in_valid & bus.in_ready;
    assign wr_fire   = xfer & phase;
    assign last_pair = wr_fire & (j == J_LAST) & (bank == B_LAST);
    assign restart   = start & (state != S_FILL);

    assign addr_even = AW'({j, 1'b0});
    assign addr_odd  = AW'({j, 1'b1});

    always_comb begin
        bank_sel       = '0;
        bank_sel[bank] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) state <= S_FILL;
                S_FILL:  if (last_pair) state <= S_DONE;
                S_DONE:  if (start) state <= S_FILL;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Offset j walks 0..D-1 inside a bank, then the bank index advances
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
            j     <= '0;
            bank  <= '0;
            hold  <= '0;
        end else if (restart) begin
            phase <= 1'b0;
            j     <= '0;
            bank  <= '0;
        end else if (xfer) begin
            phase <= ~phase;
            if (!phase) begin
                hold <= din;
            end else if (j == J_LAST) begin
                j    <= '0;
                bank <= (bank == B_LAST) ? '0 : bank + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.wr_data_a <= '0;
            bus.wr_data_b <= '0;
            bus.wr_addr_a <= '0;
            bus.wr_addr_b <= '0;
            bus.wren_a    <= '0;
            bus.wren_b    <= '0;
        end else begin
            bus.wren_a <= '0;
            bus.wren_b <= '0;
            if (wr_fire) begin
                bus.wr_data_a <= hold;
                bus.wr_data_b <= din;
                bus.wr_addr_a <= addr_even;
                bus.wr_addr_b <= addr_odd;
                bus.wren_a    <= bank_sel;
                bus.wren_b    <= bank_sel;
            end
        end
    end
endmodule

// File: tb/tb_fc_inneuron_loader.sv
// Scoreboard bench for fc_inneuron_loader: small (8 neurons, 2 banks)
// and large (100 neurons, 25 banks) instances against a pair/bank model.
module tb_fc_inneuron_loader;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int SN = 8;
    localparam int SP = 2;
    localparam int LN = 100;
    localparam int LP = 25;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic s_start = 1'b0;
    logic l_start = 1'b0;
    logic s_busy, s_done, l_busy, l_done;

    always #5 clock = ~clock;

    fc_inneuron_loader_if #(.PI(SP), .DW(DW), .AW(AW)) s_if ();
    fc_inneuron_loader_if #(.PI(LP), .DW(DW), .AW(AW)) l_if ();

    fc_inneuron_loader #(
        .INNEURON(SN), .PI(SP), .DATA_WIDTH_FC(DW), .FC_INNEURON_ADDR_WIDTH(AW)
    ) dut_s (
        .clock(clock), .reset(reset), .start(s_start),
        .bus(s_if.slave), .busy(s_busy), .done(s_done)
    );

    fc_inneuron_loader #(
        .INNEURON(LN), .PI(LP), .DATA_WIDTH_FC(DW), .FC_INNEURON_ADDR_WIDTH(AW)
    ) dut_l (
        .clock(clock), .reset(reset), .start(l_start),
        .bus(l_if.slave), .busy(l_busy), .done(l_done)
    );

    typedef struct {
        int          bank;
        int          j;
        logic [15:0] da;
        logic [15:0] db;
    } wr_t;

    wr_t         q_s[$];
    wr_t         q_l[$];
    int          checks = 0;
    int          errors = 0;
    int          idx_s = 0, idx_l = 0;
    bit          fill_s = 0, fill_l = 0;
    logic [15:0] hold_s = '0, hold_l = '0;

    function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef FC_LOADER_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Neuron idx of the pass: odd idx completes pair idx/2 -> bank k/D, offset k%D
    task automatic model_xfer(input bit lg, input logic [15:0] d);
        int          n   = lg ? LN : SN;
        int          p   = lg ? LP : SP;
        int          dd  = n / (2 * p);
        int          idx = lg ? idx_l : idx_s;
        logic [15:0] v   = relu(d);
        wr_t         w;
        if (idx % 2 == 0) begin
            if (lg) hold_l = v;
            else    hold_s = v;
        end else begin
            w.bank = (idx / 2) / dd;
            w.j    = (idx / 2) % dd;
            w.da   = lg ? hold_l : hold_s;
            w.db   = v;
            if (lg) q_l.push_back(w);
            else    q_s.push_back(w);
        end
        idx++;
        if (lg) begin
            idx_l = idx;
            if (idx == n) fill_l = 0;
        end else begin
            idx_s = idx;
            if (idx == n) fill_s = 0;
        end
    endtask

    task automatic send(input bit lg, input logic [15:0] d);
        int  n = 0;
        bit  rdy;
        if (lg) begin l_if.in_valid = 1'b1; l_if.in_data = d; end
        else    begin s_if.in_valid = 1'b1; s_if.in_data = d; end
        forever begin
            @(negedge clock);
            rdy = lg ? l_if.in_ready : s_if.in_ready;
            if (rdy) break;
            n++;
            if (n > 50) break;
        end
        if (!rdy) begin
            chk(lg ? "l_ready_timeout" : "s_ready_timeout", 0, 1);
            if (lg) l_if.in_valid = 1'b0;
            else    s_if.in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        if (lg) l_if.in_valid = 1'b0;
        else    s_if.in_valid = 1'b0;
        model_xfer(lg, d);
    endtask

    task automatic pulse_start(input bit lg);
        if (lg) l_start = 1'b1;
        else    s_start = 1'b1;
        @(posedge clock);
        #1;
        if (lg) l_start = 1'b0;
        else    s_start = 1'b0;
        if (lg && !fill_l) begin fill_l = 1; idx_l = 0; end
        if (!lg && !fill_s) begin fill_s = 1; idx_s = 0; end
        if (lg) chk("l_start_ready", {l_if.in_ready, l_busy, l_done}, 3'b110);
        else    chk("s_start_ready", {s_if.in_ready, s_busy, s_done}, 3'b110);
    endtask

    task automatic chk_done(input bit lg, input string name);
        if (lg) chk(name, {l_done, l_busy, l_if.in_ready}, 3'b100);
        else    chk(name, {s_done, s_busy, s_if.in_ready}, 3'b100);
    endtask

    task automatic chk_zero_s(input string name);
        chk(name, {s_if.in_ready, s_if.wren_a, s_if.wren_b, s_busy, s_done,
                   s_if.wr_addr_a, s_if.wr_addr_b, s_if.wr_data_a, s_if.wr_data_b}, '0);
    endtask

    task automatic mon(input bit lg);
        wr_t          w;
        logic [127:0] a, e;
        logic [31:0]  m;
        a = {32'(lg ? l_if.wren_a : 25'(s_if.wren_a)),
             32'(lg ? l_if.wren_b : 25'(s_if.wren_b)),
             lg ? l_if.wr_addr_a : s_if.wr_addr_a,
             lg ? l_if.wr_addr_b : s_if.wr_addr_b,
             lg ? l_if.wr_data_a : s_if.wr_data_a,
             lg ? l_if.wr_data_b : s_if.wr_data_b};
        if ((lg ? q_l.size() : q_s.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_write: got %0h expected no write",
                     lg ? "l" : "s", a);
            return;
        end
        w = lg ? q_l.pop_front() : q_s.pop_front();
        m = 32'd1 << w.bank;
        e = {m, m, 8'(2 * w.j), 8'(2 * w.j + 1), w.da, w.db};
        chk(lg ? "l_write" : "s_write", a, e);
    endtask

    always @(negedge clock) begin
        if (!reset && (s_if.wren_a != 0 || s_if.wren_b != 0)) mon(0);
        if (!reset && (l_if.wren_a != 0 || l_if.wren_b != 0)) mon(1);
    end

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        l_if.in_valid = 1'b0;
        l_if.in_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero_s("s_reset_outputs");
        chk("l_reset_outputs", {l_if.in_ready, l_if.wren_a, l_if.wren_b, l_busy, l_done}, '0);
        reset = 1'b0;

        // Data offered while idle must be ignored
        s_if.in_valid = 1'b1;
        s_if.in_data  = 16'h1234;
        repeat (3) @(posedge clock);
        #1;
        chk("s_idle_ignore", {s_if.in_ready, s_busy, s_done}, 3'b000);
        s_if.in_valid = 1'b0;

        pulse_start(0);
        for (int i = 1; i <= 8; i++) send(0, 16'(i));
        chk_done(0, "s_base_done");

        s_if.in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("s_done_ignore", {s_done, s_if.in_ready}, 2'b10);
        s_if.in_valid = 1'b0;

        pulse_start(0);
        send(0, 16'd1);
        send(0, 16'd2);
        repeat (3) @(posedge clock);
        #1;
        for (int i = 3; i <= 8; i++) send(0, 16'(i));
        chk_done(0, "s_gap_done");

        pulse_start(0);
        for (int i = 1; i <= 3; i++) send(0, 16'(i));
        pulse_start(0);
        for (int i = 4; i <= 8; i++) send(0, 16'(i));
        chk_done(0, "s_midstart_done");
        pulse_start(0);
        for (int i = 9; i <= 16; i++) send(0, 16'(i));
        chk_done(0, "s_restart_done");

        pulse_start(0);
        for (int i = 1; i <= 5; i++) send(0, 16'(i));
        reset = 1'b1;
        #1;
        chk_zero_s("s_midpass_reset");
        fill_s = 0;
        idx_s  = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        pulse_start(0);
        for (int i = 1; i <= 8; i++) send(0, 16'(i));
        chk_done(0, "s_post_reset_done");

        pulse_start(0);
        send(0, 16'hFFF0);
        send(0, 16'h0005);
        send(0, 16'h8000);
        send(0, 16'h7FFF);
        for (int i = 0; i < 4; i++) send(0, 16'($urandom));
        chk_done(0, "s_relu_done");

        for (int r = 0; r < 3; r++) begin
            pulse_start(0);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clock);
                    #1;
                end
                send(0, 16'($urandom));
            end
            chk_done(0, "s_random_done");
        end

        pulse_start(1);
        for (int i = 0; i < LN; i++) send(1, 16'($urandom));
        chk_done(1, "l_pass_done");

        repeat (3) @(posedge clock);
        #1;
        chk("s_queue_drained", 128'(q_s.size()), 0);
        chk("l_queue_drained", 128'(q_l.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
